// File: rtl/pipe_stall_ctl_pkg.sv
// Shared types and constants for the fetch-side stall/flush controller.
package pipe_stall_ctl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int unsigned DEF_PC_W    = 8;
    localparam int unsigned DEF_INSTR_W = 16;

    localparam logic [DEF_PC_W-1:0]    DEF_RESET_PC = 8'h00;
    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR    = '0;

    // Redirect beats stall, stall beats advance.
    function automatic state_e next_state(input logic branch, input logic stall_req);
        if (branch) begin
            return ST_FLUSH;
        end else if (stall_req) begin
            return ST_STALL;
        end
        return ST_RUN;
    endfunction

endpackage

// File: rtl/pipe_stall_ctl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_stall_ctl_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stall_ctl.sv
// Fetch-side pipeline controller: owns the PC and IF/ID register and applies
// load-use stalls and branch redirects, with saturating debug counters.
module pipe_stall_ctl
    import pipe_stall_ctl_pkg::*;
#(
    parameter int unsigned     PC_W      = DEF_PC_W,
    parameter int unsigned     INSTR_W   = DEF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC),
    parameter int unsigned     MAX_STALL = 4,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               id_ex_bubble,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               stall_err
);

    state_e state_q;
    state_e state_d;

    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] if_id_instr_q;
    logic [PC_W-1:0]    if_id_pc_q;
    logic               if_id_valid_q;
    logic               stall_err_q;
    logic [CNT_W-1:0]   run_len;

    logic stall_req;
    logic do_flush;
    logic do_stall;
    logic do_advance;
    logic err_hit;

    // A bubble already sitting in IF/ID cannot be the consumer of a load-use hazard.
    assign stall_req = hazard & if_id_valid_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = next_state(branch_taken, stall_req);
    end

    // Output / action decode
    always_comb begin
        do_flush     = 1'b0;
        do_stall     = 1'b0;
        do_advance   = 1'b0;
        id_ex_bubble = branch_taken | stall_req;
        unique case (state_d)
            ST_FLUSH: do_flush   = 1'b1;
            ST_STALL: do_stall   = 1'b1;
            default:  do_advance = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= INSTR_W'(NOP_INSTR);
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else if (do_flush) begin
            // Squash the ID instruction and drop the wrong-path fetch.
            pc_q          <= branch_target;
            if_id_instr_q <= INSTR_W'(NOP_INSTR);
            if_id_valid_q <= 1'b0;
        end else if (do_advance) begin
            pc_q          <= pc_q + PC_W'(1);
            if_id_instr_q <= instr_in;
            if_id_pc_q    <= pc_q;
            if_id_valid_q <= 1'b1;
        end
    end

    // The run length after this edge reaches MAX_STALL when it currently sits one below.
    assign err_hit = do_stall && (run_len >= CNT_W'(MAX_STALL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_err_q <= 1'b0;
        end else if (err_hit) begin
            stall_err_q <= 1'b1;
        end
    end

    pipe_stall_ctl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_stall),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    pipe_stall_ctl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_flush),
        .clr   (1'b0),
        .count (flush_cnt)
    );

    pipe_stall_ctl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_run_len (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_stall),
        .clr   (!do_stall),
        .count (run_len)
    );

    assign pc          = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;
    assign state       = state_q;
    assign stall_err   = stall_err_q;

endmodule

// File: tb/tb_pipe_stall_ctl.sv
// Directed and randomized checks of pipe_stall_ctl against a step-level reference model;
// a second instance with a 4-bit counter width exercises saturation.
module tb_pipe_stall_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [15:0] instr_in = 16'h0000;

    logic [7:0]  pc, if_id_pc, s_pc, s_if_id_pc;
    logic [15:0] if_id_instr, s_if_id_instr;
    logic        if_id_valid, id_ex_bubble, stall_err;
    logic        s_if_id_valid, s_id_ex_bubble, s_stall_err;
    logic [1:0]  state, s_state;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    pipe_stall_ctl dut (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .id_ex_bubble  (id_ex_bubble),
        .state         (state),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .stall_err     (stall_err)
    );

    pipe_stall_ctl #(
        .MAX_STALL (2),
        .CNT_W     (4)
    ) dut_s (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc            (s_pc),
        .if_id_instr   (s_if_id_instr),
        .if_id_pc      (s_if_id_pc),
        .if_id_valid   (s_if_id_valid),
        .id_ex_bubble  (s_id_ex_bubble),
        .state         (s_state),
        .stall_cnt     (s_stall_cnt),
        .flush_cnt     (s_flush_cnt),
        .stall_err     (s_stall_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] imem [256];

    // Reference model: architectural view of the fetch stage after each edge.
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic [7:0]  m_if_pc;
    logic        m_valid;
    int unsigned m_state;
    int unsigned m_stalls;
    int unsigned m_flushes;
    int unsigned m_run;
    logic        m_err;
    logic        m_err_s;

    function automatic logic [31:0] sat(input int unsigned n, input int unsigned w);
        int unsigned lim;
        lim = (32'd1 << w) - 32'd1;
        return (n > lim) ? lim : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 8'h00;
        m_instr   = 16'h0000;
        m_if_pc   = 8'h00;
        m_valid   = 1'b0;
        m_state   = 0;
        m_stalls  = 0;
        m_flushes = 0;
        m_run     = 0;
        m_err     = 1'b0;
        m_err_s   = 1'b0;
    endtask

    task automatic check_all();
        check("pc", 32'(pc), 32'(m_pc));
        check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        check("if_id_instr", 32'(if_id_instr), 32'(m_instr));
        if (m_valid) check("if_id_pc", 32'(if_id_pc), 32'(m_if_pc));
        check("state", 32'(state), m_state);
        check("stall_cnt", 32'(stall_cnt), sat(m_stalls, 16));
        check("flush_cnt", 32'(flush_cnt), sat(m_flushes, 16));
        check("stall_err", 32'(stall_err), 32'(m_err));
        check("s_stall_cnt", 32'(s_stall_cnt), sat(m_stalls, 4));
        check("s_flush_cnt", 32'(s_flush_cnt), sat(m_flushes, 4));
        check("s_stall_err", 32'(s_stall_err), 32'(m_err_s));
    endtask

    task automatic step(input logic h, input logic b, input logic [7:0] tgt);
        logic sr;
        hazard        = h;
        branch_taken  = b;
        branch_target = tgt;
        instr_in      = imem[m_pc];
        #1;
        sr = h & m_valid;
        check("id_ex_bubble", 32'(id_ex_bubble), 32'(b | sr));
        check("s_id_ex_bubble", 32'(s_id_ex_bubble), 32'(b | sr));
        @(posedge clk);
        #1;
        if (b) begin
            m_pc      = tgt;
            m_valid   = 1'b0;
            m_instr   = 16'h0000;
            m_state   = 2;
            m_flushes = m_flushes + 1;
            m_run     = 0;
        end else if (sr) begin
            m_state  = 1;
            m_stalls = m_stalls + 1;
            m_run    = m_run + 1;
            if (m_run >= 4) m_err = 1'b1;
            if (m_run >= 2) m_err_s = 1'b1;
        end else begin
            m_instr = imem[m_pc];
            m_if_pc = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 8'd1;
            m_state = 0;
            m_run   = 0;
        end
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'(i + 16'h0010) ^ {8'($urandom), 8'h00};
        model_reset();

        // Reset values, sampled while reset is still asserted.
        #3;
        check("rst_if_id_pc", 32'(if_id_pc), 32'h0);
        check_all();
        rst = 1'b0;

        // Free-running fetch up to pc=5.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
        check("pc_at_5", 32'(pc), 32'h05);

        // Single-cycle load-use stall, then resume.
        step(1'b1, 1'b0, 8'h00);
        check("stall_hold_pc", 32'(pc), 32'h05);
        step(1'b0, 1'b0, 8'h00);
        check("resume_pc", 32'(pc), 32'h06);

        // Redirect beats a simultaneous hazard; hazard on a bubble is ignored.
        step(1'b1, 1'b1, 8'h40);
        check("flush_cnt_1", 32'(flush_cnt), 32'h1);
        check("stall_cnt_1", 32'(stall_cnt), 32'h1);
        step(1'b1, 1'b0, 8'h00);
        check("hazard_ignored_pc", 32'(pc), 32'h41);

        // Back-to-back redirects.
        step(1'b0, 1'b1, 8'h80);
        step(1'b0, 1'b1, 8'h90);
        step(1'b0, 1'b0, 8'h00);

        // Four consecutive stalls trip the watchdog; it stays set.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
        check("stall_err_set", 32'(stall_err), 32'h1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("stall_err_sticky", 32'(stall_err), 32'h1);

        // PC wrap.
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'h00);
        check("pc_wrap", 32'(pc), 32'h00);

        // Asynchronous reset between edges while stalled.
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_if_id_pc", 32'(if_id_pc), 32'h0);
        check_all();
        #2;
        rst = 1'b0;

        // Randomized traffic; the narrow instance saturates along the way.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0), 8'($urandom));
        end
        check("s_stall_saturated", 32'(s_stall_cnt), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
